// File: rtl/tc_mul_pkg.sv
// Shared helpers for the TrackletCalculator pipelined multiplier: product
// width, signed saturation bounds and parameter legality.
package tc_mul_pkg;

    localparam int unsigned BOUND_W = 128;

    typedef logic signed [BOUND_W-1:0] bound_t;

    // Full signed product width after one-bit extension of each operand.
    function automatic int unsigned prod_w(input int unsigned a_w, input int unsigned b_w);
        return a_w + b_w + 2;
    endfunction

    // Largest value representable in a w-bit two's complement word.
    function automatic bound_t smax(input int unsigned w);
        return (bound_t'(1) <<< (w - 1)) - bound_t'(1);
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic bound_t smin(input int unsigned w);
        return -(bound_t'(1) <<< (w - 1));
    endfunction

    // Legal parameter space of the multiplier.
    function automatic logic params_ok(input int unsigned stages,
                                       input int unsigned shift,
                                       input int unsigned out_w,
                                       input int unsigned a_w,
                                       input int unsigned b_w);
        return (stages >= 1) && (stages <= 4) &&
               (shift <= a_w + b_w - 1) &&
               (out_w >= 2) && (out_w <= a_w + b_w + 1);
    endfunction

endpackage

// File: rtl/tc_mul_round_sat.sv
// Post-multiply scaling: optional half-up rounding, arithmetic right shift,
// range check and either saturation or wrap into the OUT_W result.
module tc_mul_round_sat
    import tc_mul_pkg::*;
#(
    parameter int unsigned PW    = 33,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned ROUND = 0,
    parameter int unsigned SAT   = 1,
    parameter int unsigned OUT_W = 31
) (
    input  logic signed [PW-1:0]    prod,
    output logic        [OUT_W-1:0] res_c,
    output logic                    ovf_c
);

    // One guard bit so the rounding add can never overflow.
    localparam int unsigned RW  = PW + 1;
    localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [RW-1:0] RND = ((ROUND != 0) && (SHIFT > 0)) ? (RW'(1) << RSH) : '0;
    localparam logic signed [RW-1:0] MAXV = RW'(smax(OUT_W));
    localparam logic signed [RW-1:0] MINV = RW'(smin(OUT_W));

    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] r;
    logic                 hi;
    logic                 lo;

    // Round, shift, range-check and clamp or wrap.
    always_comb begin
        sum   = $signed({prod[PW-1], prod}) + $signed(RND);
        r     = sum >>> SHIFT;
        hi    = r > MAXV;
        lo    = r < MINV;
        ovf_c = hi | lo;
        res_c = r[OUT_W-1:0];
        if (SAT != 0) begin
            if (hi) begin
                res_c = MAXV[OUT_W-1:0];
            end else if (lo) begin
                res_c = MINV[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tc_pipe_mul.sv
// Parametrised pipelined fixed-point multiplier with valid/ready handshake.
// Stage 1 holds operands, middle stages hold the raw product, the last stage
// holds the scaled result. One global enable advances or freezes everything.
module tc_pipe_mul
    import tc_mul_pkg::*;
#(
    parameter int unsigned A_W      = 13,
    parameter int unsigned B_W      = 18,
    parameter int unsigned A_SIGNED = 0,
    parameter int unsigned B_SIGNED = 1,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned ROUND    = 0,
    parameter int unsigned SAT      = 1,
    parameter int unsigned OUT_W    = 31
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] p,
    output logic             ovf
);

    localparam int unsigned PW = prod_w(A_W, B_W);
    localparam int unsigned NM = (STAGES > 2) ? STAGES - 2 : 0;

    if (!params_ok(STAGES, SHIFT, OUT_W, A_W, B_W)) begin : g_bad_params
        $error("tc_pipe_mul: illegal STAGES, SHIFT or OUT_W");
    end

    logic                 en;
    logic [STAGES-1:0]    vld;
    logic signed [A_W:0]  a_x;
    logic signed [B_W:0]  b_x;
    logic signed [A_W:0]  a_s;
    logic signed [B_W:0]  b_s;
    logic signed [PW-1:0] prod_m;
    logic signed [PW-1:0] prod_l;
    logic [OUT_W-1:0]     res_c;
    logic                 ovf_c;

    // Pipeline advances whenever the output slot is empty or being drained.
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = vld[STAGES-1];

    // Extend each operand by one bit so the signed product is exact.
    assign a_x = $signed({a[A_W-1] & (A_SIGNED != 0), a});
    assign b_x = $signed({b[B_W-1] & (B_SIGNED != 0), b});

    // Valid chain shifts with the data; bubbles travel as zeros.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= (vld << 1) | STAGES'(in_valid);
        end
    end

    if (STAGES >= 2) begin : g_opreg
        logic signed [A_W:0] a_q;
        logic signed [B_W:0] b_q;

        // Operand registers (stage 1).
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (en) begin
                a_q <= a_x;
                b_q <= b_x;
            end
        end

        assign a_s = a_q;
        assign b_s = b_q;
    end else begin : g_opcomb
        assign a_s = a_x;
        assign b_s = b_x;
    end

    assign prod_m = PW'(a_s) * PW'(b_s);

    for (genvar s = 0; s < NM; s++) begin : g_mreg
        logic signed [PW-1:0] d;
        logic signed [PW-1:0] q;

        if (s == 0) begin : g_first
            assign d = prod_m;
        end else begin : g_next
            assign d = g_mreg[s-1].q;
        end

        // Raw product register (middle stage).
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                q <= '0;
            end else if (en) begin
                q <= d;
            end
        end
    end

    if (NM == 0) begin : g_no_mreg
        assign prod_l = prod_m;
    end else begin : g_tap_mreg
        assign prod_l = g_mreg[NM-1].q;
    end

    tc_mul_round_sat #(
        .PW    (PW),
        .SHIFT (SHIFT),
        .ROUND (ROUND),
        .SAT   (SAT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .prod  (prod_l),
        .res_c (res_c),
        .ovf_c (ovf_c)
    );

    // Output register (last stage).
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            p   <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            p   <= res_c;
            ovf <= ovf_c;
        end
    end

endmodule

// File: tb/tb_tc_pipe_mul.sv
// Bench for tc_pipe_mul: nine parameter sets share one input stream, each
// with its own expected/observed queues.
module tb_tc_pipe_mul;

    localparam int NC = 9;
    //                          0  1  2  3  4  5  6  7  8
    localparam int C_AS[NC] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
    localparam int C_ST[NC] = '{3, 3, 3, 3, 3, 3, 1, 4, 2};
    localparam int C_SH[NC] = '{0, 4, 4, 0, 0, 0, 0, 5, 3};
    localparam int C_RN[NC] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
    localparam int C_SA[NC] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
    localparam int C_OW[NC] = '{31, 31, 31, 16, 16, 31, 31, 20, 24};

    typedef struct {
        longint p;
        logic   ovf;
        int     cyc;
    } item_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [12:0] a;
    logic [17:0] b;
    logic        ir    [NC];
    logic        ov    [NC];
    logic        ovf_w [NC];
    longint      pv    [NC];
    logic [30:0] p0, p1, p2, p5, p6;
    logic [15:0] p3, p4;
    logic [19:0] p7;
    logic [23:0] p8;

    item_t exp_q [NC][$];
    item_t got_q [NC][$];
    int    cycle = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  acc0;

    tc_pipe_mul u_c0 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
                      .out_valid(ov[0]), .out_ready(out_ready), .p(p0), .ovf(ovf_w[0]));
    tc_pipe_mul #(.SHIFT(4), .ROUND(1)) u_c1 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
                      .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .p(p1), .ovf(ovf_w[1]));
    tc_pipe_mul #(.SHIFT(4), .ROUND(0)) u_c2 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
                      .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .p(p2), .ovf(ovf_w[2]));
    tc_pipe_mul #(.OUT_W(16), .SAT(1)) u_c3 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
                      .a(a), .b(b), .out_valid(ov[3]), .out_ready(out_ready), .p(p3), .ovf(ovf_w[3]));
    tc_pipe_mul #(.OUT_W(16), .SAT(0)) u_c4 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[4]),
                      .a(a), .b(b), .out_valid(ov[4]), .out_ready(out_ready), .p(p4), .ovf(ovf_w[4]));
    tc_pipe_mul #(.A_SIGNED(1)) u_c5 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[5]),
                      .a(a), .b(b), .out_valid(ov[5]), .out_ready(out_ready), .p(p5), .ovf(ovf_w[5]));
    tc_pipe_mul #(.STAGES(1)) u_c6 (.ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[6]),
                      .a(a), .b(b), .out_valid(ov[6]), .out_ready(out_ready), .p(p6), .ovf(ovf_w[6]));
    tc_pipe_mul #(.STAGES(4), .SHIFT(5), .ROUND(1), .OUT_W(20), .A_SIGNED(1), .SAT(1)) u_c7 (.ap_clk(clk),
                      .ap_rst(rst), .in_valid(in_valid), .in_ready(ir[7]), .a(a), .b(b), .out_valid(ov[7]),
                      .out_ready(out_ready), .p(p7), .ovf(ovf_w[7]));
    tc_pipe_mul #(.STAGES(2), .SHIFT(3), .ROUND(0), .OUT_W(24), .SAT(0)) u_c8 (.ap_clk(clk), .ap_rst(rst),
                      .in_valid(in_valid), .in_ready(ir[8]), .a(a), .b(b), .out_valid(ov[8]),
                      .out_ready(out_ready), .p(p8), .ovf(ovf_w[8]));

    always_comb begin
        pv[0] = longint'($signed(p0));
        pv[1] = longint'($signed(p1));
        pv[2] = longint'($signed(p2));
        pv[3] = longint'($signed(p3));
        pv[4] = longint'($signed(p4));
        pv[5] = longint'($signed(p5));
        pv[6] = longint'($signed(p6));
        pv[7] = longint'($signed(p7));
        pv[8] = longint'($signed(p8));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result for parameter set k.
    function automatic item_t model(input int k, input logic [12:0] av, input logic [17:0] bv);
        item_t  it;
        longint ax, bx, pr, hi, lo;
        int     ow;
        ax = (C_AS[k] != 0) ? longint'($signed(av)) : longint'(av);
        bx = longint'($signed(bv));
        pr = ax * bx;
        if (C_RN[k] != 0 && C_SH[k] > 0) pr = pr + (64'sd1 <<< (C_SH[k] - 1));
        pr = pr >>> C_SH[k];
        ow = C_OW[k];
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        it.ovf = (pr > hi) || (pr < lo);
        if (C_SA[k] != 0) it.p = (pr > hi) ? hi : ((pr < lo) ? lo : pr);
        else              it.p = (pr <<< (64 - ow)) >>> (64 - ow);
        it.cyc = 0;
        return it;
    endfunction

    // Record transfers about to happen on the next edge, then advance one cycle.
    task automatic tick();
        item_t it;
        #1;
        acc0 = in_valid && ir[0];
        for (int k = 0; k < NC; k++) begin
            if (in_valid && ir[k]) begin
                it = model(k, a, b);
                it.cyc = cycle;
                exp_q[k].push_back(it);
            end
            if (ov[k] && out_ready) begin
                it.p = pv[k];
                it.ovf = ovf_w[k];
                it.cyc = cycle;
                got_q[k].push_back(it);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle_clear();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        for (int k = 0; k < NC; k++) begin
            exp_q[k].delete();
            got_q[k].delete();
        end
    endtask

    task automatic send_one(input logic [12:0] av, input logic [17:0] bv);
        idle_clear();
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < NC; k++) begin
            n_cmp += 3;
            if (ov[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", k, ov[k]); end
            if (pv[k] !== 64'sd0) begin n_bad++; $display("FAIL reset_p[%0d]: got %0d want 0", k, pv[k]); end
            if (ovf_w[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf_w[k]); end
            n_cmp++;
            if (ir[k] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
        end
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_defaults();
        send_one(13'd8191, 18'h20000);
        n_cmp += 2;
        if (exp_q[0].size() != 1) begin n_bad++; $display("FAIL def_accept: got %0d want 1", exp_q[0].size()); end
        if (got_q[0].size() != 1) begin
            n_bad++; $display("FAIL def_count: got %0d want 1", got_q[0].size());
        end else begin
            n_cmp += 3;
            if (got_q[0][0].p !== -64'sd1073610752) begin
                n_bad++; $display("FAIL def_p: got %0d want -1073610752", got_q[0][0].p);
            end
            if (got_q[0][0].ovf !== 1'b0) begin n_bad++; $display("FAIL def_ovf: got %b want 0", got_q[0][0].ovf); end
            if (got_q[0][0].cyc - cycle + 7 !== 3) begin
                n_bad++; $display("FAIL def_latency: got %0d want 3", got_q[0][0].cyc - cycle + 7);
            end
        end
        for (int k = 0; k < NC; k++) begin
            n_cmp++;
            if (got_q[k].size() != 1 || exp_q[k].size() != 1) begin
                n_bad++; $display("FAIL latency_count[%0d]: got %0d want 1", k, got_q[k].size());
            end else if (got_q[k][0].cyc - exp_q[k][0].cyc !== C_ST[k]) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d want %0d", k, got_q[k][0].cyc - exp_q[k][0].cyc, C_ST[k]);
            end
        end
        n_cmp++;
        if (got_q[6].size() != 1 || got_q[6][0].p !== -64'sd1073610752) begin
            n_bad++; $display("FAIL stages1_p: got %0d want -1073610752", (got_q[6].size() > 0) ? got_q[6][0].p : 0);
        end
    endtask

    task automatic test_round();
        send_one(13'd3, 18'd3);
        n_cmp += 2;
        if (got_q[1].size() != 1 || got_q[1][0].p !== 64'sd1 || got_q[1][0].ovf !== 1'b0) begin
            n_bad++; $display("FAIL round_half_up: got %0d want 1", (got_q[1].size() > 0) ? got_q[1][0].p : -1);
        end
        if (got_q[2].size() != 1 || got_q[2][0].p !== 64'sd0 || got_q[2][0].ovf !== 1'b0) begin
            n_bad++; $display("FAIL round_trunc: got %0d want 0", (got_q[2].size() > 0) ? got_q[2][0].p : -1);
        end
    endtask

    task automatic test_sat_wrap();
        send_one(13'd8191, 18'h1FFFF);
        n_cmp += 3;
        if (got_q[3].size() != 1 || got_q[3][0].p !== 64'sd32767 || got_q[3][0].ovf !== 1'b1) begin
            n_bad++; $display("FAIL sat16: got %0d want 32767 ovf 1", (got_q[3].size() > 0) ? got_q[3][0].p : 0);
        end
        if (got_q[4].size() != 1 || got_q[4][0].p !== -64'sd8191 || got_q[4][0].ovf !== 1'b1) begin
            n_bad++; $display("FAIL wrap16: got %0d want -8191 ovf 1", (got_q[4].size() > 0) ? got_q[4][0].p : 0);
        end
        if (got_q[0].size() != 1 || got_q[0][0].p !== 64'sd1073602561 || got_q[0][0].ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL full_max: got %0d want 1073602561 ovf 0", (got_q[0].size() > 0) ? got_q[0][0].p : 0);
        end
    endtask

    task automatic test_signed();
        send_one(13'h1000, 18'h20000);
        n_cmp += 2;
        if (got_q[5].size() != 1 || got_q[5][0].p !== 64'sd536870912 || got_q[5][0].ovf !== 1'b0) begin
            n_bad++; $display("FAIL both_signed: got %0d want 536870912", (got_q[5].size() > 0) ? got_q[5][0].p : 0);
        end
        if (got_q[0].size() != 1 || got_q[0][0].p !== -64'sd536870912) begin
            n_bad++; $display("FAIL a_unsigned: got %0d want -536870912", (got_q[0].size() > 0) ? got_q[0][0].p : 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] va [8];
        logic [17:0] vb [8];
        int sent, stalls, n;
        idle_clear();
        for (int i = 0; i < 8; i++) begin
            va[i] = 13'($urandom);
            vb[i] = 18'($urandom);
        end
        va[2] = 13'd8191;
        vb[2] = 18'h1FFFF;
        va[5] = 13'h1000;
        vb[5] = 18'h20000;
        sent = 0;
        stalls = 0;
        for (int c = 0; c < 80 && (sent < 8 || got_q[0].size() < 8); c++) begin
            if (got_q[0].size() > 0 && stalls < 4) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < 8);
            if (sent < 8) begin
                a = va[sent];
                b = vb[sent];
            end
            #1;
            if (ov[0] && !out_ready) begin
                n_cmp++;
                if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", ir[0]); end
            end
            tick();
            if (acc0) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        n_cmp += 2;
        if (stalls != 4) begin n_bad++; $display("FAIL stall_cycles: got %0d want 4", stalls); end
        if (exp_q[0].size() != 8) begin n_bad++; $display("FAIL stream_accepted: got %0d want 8", exp_q[0].size()); end
        for (int k = 0; k < NC; k++) begin
            n_cmp++;
            if (got_q[k].size() != exp_q[k].size()) begin
                n_bad++;
                $display("FAIL stream_count[%0d]: got %0d want %0d", k, got_q[k].size(), exp_q[k].size());
            end
            n = (got_q[k].size() < exp_q[k].size()) ? got_q[k].size() : exp_q[k].size();
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (got_q[k][i].p !== exp_q[k][i].p || got_q[k][i].ovf !== exp_q[k][i].ovf) begin
                    n_bad++;
                    $display("FAIL stream[%0d][%0d]: got p=%0d ovf=%b want p=%0d ovf=%b", k, i,
                             got_q[k][i].p, got_q[k][i].ovf, exp_q[k][i].p, exp_q[k][i].ovf);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        idle_clear();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 13'(1000 + i);
            b = 18'(77 + i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        for (int k = 0; k < NC; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b0 || pv[k] !== 64'sd0 || ovf_w[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset[%0d]: got valid=%b p=%0d ovf=%b want 0/0/0", k, ov[k], pv[k], ovf_w[k]);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < NC; k++) begin
            exp_q[k].delete();
            got_q[k].delete();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle[%0d]: got %b want 0", i, ov[0]); end
            tick();
        end
        a = 13'd100;
        b = 18'h3FFFB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (got_q[0].size() != 1 || exp_q[0].size() != 1) begin
            n_bad++; $display("FAIL post_reset_count: got %0d want 1", got_q[0].size());
        end else begin
            n_cmp += 2;
            if (got_q[0][0].p !== -64'sd500) begin
                n_bad++; $display("FAIL post_reset_p: got %0d want -500", got_q[0][0].p);
            end
            if (got_q[0][0].cyc - exp_q[0][0].cyc !== 3) begin
                n_bad++; $display("FAIL post_reset_latency: got %0d want 3", got_q[0][0].cyc - exp_q[0][0].cyc);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        acc0 = 1'b0;
        test_reset();
        test_defaults();
        test_round();
        test_sat_wrap();
        test_signed();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
